// File: rtl/dcache_pkg.sv
// Shared types, widths and address helpers for the data cache controller.
// The optional hit/miss statistics block is enabled by defining DCACHE_STATS_EN.
package dcache_pkg;

    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 32;
    localparam int INDEX_W     = 5;
    localparam int BLOCK_WORDS = 4;
    localparam int OFF_W       = $clog2(BLOCK_WORDS);
    localparam int BYTE_W      = 2;
    localparam int TAG_W       = ADDR_W - INDEX_W - OFF_W - BYTE_W;
    localparam int LINES       = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        REFILL  = 2'd2,
        WR_THRU = 2'd3
    } dcache_state_e;

    typedef struct packed {
        logic                                valid;
        logic [TAG_W-1:0]                    tag;
        logic [BLOCK_WORDS-1:0][DATA_W-1:0]  data;
    } dcache_line_t;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
        logic [OFF_W-1:0]   off;
        logic [BYTE_W-1:0]  byte_off;
    } dcache_addr_t;

    // Break a byte address into tag / line index / word offset / byte offset.
    function automatic dcache_addr_t split_addr(input logic [ADDR_W-1:0] a);
        dcache_addr_t f;
        f.tag      = a[ADDR_W-1 -: TAG_W];
        f.index    = a[BYTE_W+OFF_W +: INDEX_W];
        f.off      = a[BYTE_W +: OFF_W];
        f.byte_off = a[BYTE_W-1:0];
        return f;
    endfunction

    // Line-aligned base address used for block refills.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W+BYTE_W], {(OFF_W+BYTE_W){1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// Core-side and memory-side signal bundle of the data cache controller.
// master = core/memory environment, slave = the cache controller.
interface dcache_controller_if;
    import dcache_pkg::*;

    // core side
    logic                          MemRead;
    logic                          MemWrite;
    logic [ADDR_W-1:0]             addr;
    logic [DATA_W-1:0]             wdata;
    logic [DATA_W-1:0]             ReadData_m;
    logic                          Stall;
    // main memory side
    logic                          mem_rd_req;
    logic                          mem_wr_req;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_wdata;
    logic [DATA_W*BLOCK_WORDS-1:0] mem_rdata;
    logic                          mem_ready;

    modport master (
        output MemRead, MemWrite, addr, wdata, mem_rdata, mem_ready,
        input  ReadData_m, Stall, mem_rd_req, mem_wr_req, mem_addr, mem_wdata
    );

    modport slave (
        input  MemRead, MemWrite, addr, wdata, mem_rdata, mem_ready,
        output ReadData_m, Stall, mem_rd_req, mem_wr_req, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache.
// Valid bits clear asynchronously on reset; tag and data are never reset.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [INDEX_W-1:0]                 rd_index,
    output dcache_line_t                       rd_line,
    input  logic                               line_we,
    input  logic [INDEX_W-1:0]                 line_index,
    input  logic [TAG_W-1:0]                   line_tag,
    input  logic [BLOCK_WORDS-1:0][DATA_W-1:0] line_data,
    input  logic                               word_we,
    input  logic [INDEX_W-1:0]                 word_index,
    input  logic [OFF_W-1:0]                   word_off,
    input  logic [DATA_W-1:0]                  word_data
);

    logic [LINES-1:0]                   valid_q;
    logic [LINES-1:0]                   valid_d;
    logic [TAG_W-1:0]                   tag_q  [LINES];
    logic [BLOCK_WORDS-1:0][DATA_W-1:0] data_q [LINES];

    // A completed refill marks its line valid; nothing else changes validity.
    always_comb begin
        valid_d = valid_q;
        if (line_we) begin
            valid_d[line_index] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid register with asynchronous invalidate-all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= {LINES{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data storage: whole-line refill or single-word store-hit update.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[line_index]  <= line_tag;
            data_q[line_index] <= line_data;
        end else if (word_we) begin
            data_q[word_index][word_off] <= word_data;
        end
    end

    // Asynchronous read of the addressed line for the hit check.
    always_comb begin
        rd_line.valid = valid_q[rd_index];
        rd_line.tag   = tag_q[rd_index];
        rd_line.data  = data_q[rd_index];
    end

endmodule

// File: rtl/dcache_controller_chk.sv
// Simulation-only protocol checks on the core request interface.
module dcache_controller_chk (
    input logic clk,
    input logic rst,
    input logic mem_read,
    input logic mem_write
);

    // A load and a store in the same cycle is illegal; the store gets serviced.
    read_write_exclusive_a : assert property (@(posedge clk) disable iff (rst)
        !(mem_read && mem_write))
        else $error("dcache: MemRead and MemWrite asserted in the same cycle");

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits return data combinationally; misses refill a whole line and
// return the word registered in the REFILL cycle. Stores always go to memory.
// Define DCACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               RST,
    dcache_controller_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);

    dcache_state_e                      state_q, state_d;
    logic [DATA_W-1:0]                  rdata_q, rdata_d;
    logic                               mem_rd_req_q, mem_rd_req_d;
    logic                               mem_wr_req_q, mem_wr_req_d;
    logic [ADDR_W-1:0]                  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]                  mem_wdata_q, mem_wdata_d;
    logic [OFF_W-1:0]                   req_off_q, req_off_d;

    dcache_addr_t                       req_f;
    dcache_addr_t                       fill_f;
    dcache_line_t                       rd_line;
    logic [BLOCK_WORDS-1:0][DATA_W-1:0] fill_block_s;
    logic                               hit_s;
    logic [DATA_W-1:0]                  hit_word_s;
    logic                               stall_s;
    logic [DATA_W-1:0]                  rdata_out_s;
    logic                               line_we_s;
    logic                               word_we_s;
    logic                               hit_evt_s;
    logic                               miss_evt_s;
    logic                               unused_s;

    // The refill target comes from the latched block address, so the line
    // is written to the right place even if the core address moves.
    assign req_f        = split_addr(bus.addr);
    assign fill_f       = split_addr(mem_addr_q);
    assign fill_block_s = bus.mem_rdata;
    assign hit_s        = rd_line.valid && (rd_line.tag == req_f.tag);
    assign hit_word_s   = rd_line.data[req_f.off];
    assign unused_s     = ^{req_f.byte_off, fill_f.off, fill_f.byte_off};

    dcache_array u_array (
        .clk        (clk),
        .rst        (RST),
        .rd_index   (req_f.index),
        .rd_line    (rd_line),
        .line_we    (line_we_s),
        .line_index (fill_f.index),
        .line_tag   (fill_f.tag),
        .line_data  (fill_block_s),
        .word_we    (word_we_s),
        .word_index (req_f.index),
        .word_off   (req_f.off),
        .word_data  (bus.wdata)
    );

    // Next-state, request and core-facing output logic.
    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        mem_rd_req_d = mem_rd_req_q;
        mem_wr_req_d = mem_wr_req_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        req_off_d    = req_off_q;
        stall_s      = 1'b0;
        rdata_out_s  = rdata_q;
        line_we_s    = 1'b0;
        word_we_s    = 1'b0;
        hit_evt_s    = 1'b0;
        miss_evt_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.MemWrite) begin
                    // Store takes priority over a simultaneous load.
                    stall_s      = 1'b1;
                    state_d      = WR_THRU;
                    mem_wr_req_d = 1'b1;
                    mem_addr_d   = bus.addr;
                    mem_wdata_d  = bus.wdata;
                    word_we_s    = hit_s;
                    hit_evt_s    = hit_s;
                    miss_evt_s   = !hit_s;
                end else if (bus.MemRead) begin
                    if (hit_s) begin
                        rdata_out_s = hit_word_s;
                        rdata_d     = hit_word_s;
                        hit_evt_s   = 1'b1;
                    end else begin
                        stall_s      = 1'b1;
                        state_d      = RD_MISS;
                        mem_rd_req_d = 1'b1;
                        mem_addr_d   = block_base(bus.addr);
                        req_off_d    = req_f.off;
                        miss_evt_s   = 1'b1;
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            RD_MISS: begin
                stall_s = 1'b1;
                if (bus.mem_ready) begin
                    line_we_s    = 1'b1;
                    rdata_d      = fill_block_s[req_off_q];
                    mem_rd_req_d = 1'b0;
                    state_d      = REFILL;
                end else begin
                    state_d = RD_MISS;
                end
            end
            REFILL: begin
                // Core consumes the registered word this cycle.
                state_d = IDLE;
            end
            WR_THRU: begin
                if (bus.mem_ready) begin
                    mem_wr_req_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                mem_rd_req_d = 1'b0;
                mem_wr_req_d = 1'b0;
            end
        endcase
    end

    // Controller state and memory-request registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            rdata_q      <= {DATA_W{1'b0}};
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            req_off_q    <= {OFF_W{1'b0}};
        end else begin
            state_q      <= state_d;
            rdata_q      <= rdata_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_wr_req_q <= mem_wr_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            req_off_q    <= req_off_d;
        end
    end

    // Core outputs are forced quiet while reset is held, even with a request pending.
    assign bus.Stall      = stall_s & ~RST;
    assign bus.ReadData_m = RST ? {DATA_W{1'b0}} : rdata_out_s;
    assign bus.mem_rd_req = mem_rd_req_q;
    assign bus.mem_wr_req = mem_wr_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating hit/miss event counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_evt_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if (miss_evt_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_stats_s;
    assign unused_stats_s = hit_evt_s ^ miss_evt_s;
`endif

`ifndef SYNTHESIS
    dcache_controller_chk u_chk (
        .clk       (clk),
        .rst       (RST),
        .mem_read  (bus.MemRead),
        .mem_write (bus.MemWrite)
    );
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller: cold miss/refill,
// read hits, write-through hit and miss, reset during a refill, and the
// statistics counters when DCACHE_STATS_EN is defined.
module tb_dcache_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dcache_controller_if bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_controller dut (
        .clk      (clk),
        .RST      (rst),
        .bus      (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of core/memory inputs on the falling edge, then settle.
    task automatic step(input logic rd, input logic wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic rdy);
        @(negedge clk);
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.addr      = a;
        bus.wdata     = wd;
        bus.mem_ready = rdy;
        #2;
    endtask

    // Hard stop if the run ever overruns.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.addr      = 12'h000;
        bus.wdata     = 32'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst_stall", {31'd0, bus.Stall}, 32'd0);
        check("rst_rdata", bus.ReadData_m, 32'd0);
        check("rst_rdreq", {31'd0, bus.mem_rd_req}, 32'd0);
        check("rst_wrreq", {31'd0, bus.mem_wr_req}, 32'd0);
        check("rst_maddr", {20'd0, bus.mem_addr}, 32'd0);
        check("rst_mwdata", bus.mem_wdata, 32'd0);
`ifdef DCACHE_STATS_EN
        check("rst_hitcnt", hit_cnt, 32'd0);
        check("rst_misscnt", miss_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Cold load 0x040: 4 stall cycles, memory ready on 3rd RD_MISS cycle
        step(1'b1, 1'b0, 12'h040, 32'h0, 1'b0);
        check("miss_c0_stall", {31'd0, bus.Stall}, 32'd1);
        step(1'b1, 1'b0, 12'h040, 32'h0, 1'b0);
        check("miss_c1_stall", {31'd0, bus.Stall}, 32'd1);
        check("miss_c1_rdreq", {31'd0, bus.mem_rd_req}, 32'd1);
        check("miss_c1_maddr", {20'd0, bus.mem_addr}, 32'h040);
        step(1'b1, 1'b0, 12'h040, 32'h0, 1'b0);
        check("miss_c2_stall", {31'd0, bus.Stall}, 32'd1);
        step(1'b1, 1'b0, 12'h040, 32'h0, 1'b1);
        check("miss_c3_stall", {31'd0, bus.Stall}, 32'd1);
        check("miss_c3_rdreq", {31'd0, bus.mem_rd_req}, 32'd1);
        step(1'b1, 1'b0, 12'h040, 32'h0, 1'b0);
        check("refill_stall", {31'd0, bus.Stall}, 32'd0);
        check("refill_rdata", bus.ReadData_m, 32'h0000_0011);
        check("refill_rdreq", {31'd0, bus.mem_rd_req}, 32'd0);

        // Load 0x048 hits: word 2 of the line, no stall, no memory request
        step(1'b1, 1'b0, 12'h048, 32'h0, 1'b0);
        check("hit048_stall", {31'd0, bus.Stall}, 32'd0);
        check("hit048_rdata", bus.ReadData_m, 32'h0000_0033);
        check("hit048_rdreq", {31'd0, bus.mem_rd_req}, 32'd0);
        step(1'b0, 1'b0, 12'h000, 32'h0, 1'b0);
        check("idle_stall", {31'd0, bus.Stall}, 32'd0);
        check("idle_hold_rdata", bus.ReadData_m, 32'h0000_0033);

        // Store hit 0x044 <= DEADBEEF, write-through until mem_ready
        step(1'b0, 1'b1, 12'h044, 32'hDEAD_BEEF, 1'b0);
        check("wr044_c0_stall", {31'd0, bus.Stall}, 32'd1);
        step(1'b0, 1'b1, 12'h044, 32'hDEAD_BEEF, 1'b0);
        check("wr044_c1_stall", {31'd0, bus.Stall}, 32'd1);
        check("wr044_c1_wrreq", {31'd0, bus.mem_wr_req}, 32'd1);
        check("wr044_c1_mwdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("wr044_c1_maddr", {20'd0, bus.mem_addr}, 32'h044);
        step(1'b0, 1'b1, 12'h044, 32'hDEAD_BEEF, 1'b1);
        check("wr044_rdy_stall", {31'd0, bus.Stall}, 32'd0);
        check("wr044_rdy_wrreq", {31'd0, bus.mem_wr_req}, 32'd1);
        step(1'b1, 1'b0, 12'h044, 32'h0, 1'b0);
        check("hit044_stall", {31'd0, bus.Stall}, 32'd0);
        check("hit044_rdata", bus.ReadData_m, 32'hDEAD_BEEF);
        check("hit044_wrreq", {31'd0, bus.mem_wr_req}, 32'd0);

        // Store miss 0x840 (same index, other tag): memory only, no allocate
        step(1'b0, 1'b1, 12'h840, 32'h1234_5678, 1'b0);
        check("wr840_c0_stall", {31'd0, bus.Stall}, 32'd1);
        step(1'b0, 1'b1, 12'h840, 32'h1234_5678, 1'b0);
        check("wr840_c1_maddr", {20'd0, bus.mem_addr}, 32'h840);
        check("wr840_c1_mwdata", bus.mem_wdata, 32'h1234_5678);
        check("wr840_c1_wrreq", {31'd0, bus.mem_wr_req}, 32'd1);
        step(1'b0, 1'b1, 12'h840, 32'h1234_5678, 1'b1);
        check("wr840_rdy_stall", {31'd0, bus.Stall}, 32'd0);
        step(1'b0, 1'b0, 12'h000, 32'h0, 1'b0);
`ifdef DCACHE_STATS_EN
        check("stats_hitcnt", hit_cnt, 32'd3);
        check("stats_misscnt", miss_cnt, 32'd2);
`endif
        step(1'b1, 1'b0, 12'h040, 32'h0, 1'b0);
        check("hit040_stall", {31'd0, bus.Stall}, 32'd0);
        check("hit040_rdata", bus.ReadData_m, 32'h0000_0011);
        step(1'b1, 1'b0, 12'h04C, 32'h0, 1'b0);
        check("hit04c_rdata", bus.ReadData_m, 32'h0000_0044);
        step(1'b0, 1'b0, 12'h000, 32'h0, 1'b0);
`ifdef DCACHE_STATS_EN
        check("stats2_hitcnt", hit_cnt, 32'd5);
        check("stats2_misscnt", miss_cnt, 32'd2);
`endif

        // Reset two cycles into a read miss of 0x0A0
        step(1'b1, 1'b0, 12'h0A0, 32'h0, 1'b0);
        check("miss0a0_stall", {31'd0, bus.Stall}, 32'd1);
        step(1'b1, 1'b0, 12'h0A0, 32'h0, 1'b0);
        check("miss0a0_rdreq", {31'd0, bus.mem_rd_req}, 32'd1);
        step(1'b1, 1'b0, 12'h0A0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("midrst_stall", {31'd0, bus.Stall}, 32'd0);
        check("midrst_rdreq", {31'd0, bus.mem_rd_req}, 32'd0);
        check("midrst_maddr", {20'd0, bus.mem_addr}, 32'd0);
        check("midrst_rdata", bus.ReadData_m, 32'd0);
`ifdef DCACHE_STATS_EN
        check("midrst_hitcnt", hit_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        bus.MemRead = 1'b0;
        bus.mem_rdata = {32'h0000_0088, 32'h0000_0077, 32'h0000_0066, 32'h0000_0055};

        // 0x040 was invalidated: it misses again and refills with new data
        step(1'b1, 1'b0, 12'h040, 32'h0, 1'b0);
        check("remiss_stall", {31'd0, bus.Stall}, 32'd1);
        step(1'b1, 1'b0, 12'h040, 32'h0, 1'b1);
        check("remiss_rdreq", {31'd0, bus.mem_rd_req}, 32'd1);
        check("remiss_maddr", {20'd0, bus.mem_addr}, 32'h040);
        step(1'b1, 1'b0, 12'h040, 32'h0, 1'b0);
        check("rerefill_stall", {31'd0, bus.Stall}, 32'd0);
        check("rerefill_rdata", bus.ReadData_m, 32'h0000_0055);
        step(1'b1, 1'b0, 12'h048, 32'h0, 1'b0);
        check("rehit048_rdata", bus.ReadData_m, 32'h0000_0077);
        step(1'b0, 1'b0, 12'h000, 32'h0, 1'b0);
`ifdef DCACHE_STATS_EN
        check("stats3_hitcnt", hit_cnt, 32'd1);
        check("stats3_misscnt", miss_cnt, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
